// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master
// Brief    : Single-outstanding Wishbone classic master driven by a
//            valid/ready command stream, with address-window decode and timeout.
// Revision : 1.0
// ============================================================================
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ADDR_BASE      = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hF000_0000
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic        wbs_we_o,
    output logic [3:0]  wbs_sel_o,
    output logic [31:0] wbs_adr_o,
    output logic [31:0] wbs_dat_o,
    input  logic        wbs_ack_i,
    input  logic [31:0] wbs_dat_i,
    output logic        busy,
    output logic [15:0] err_count
);

    localparam logic [1:0]  ERR_OK      = 2'b00;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b01;
    localparam logic [1:0]  ERR_DECODE  = 2'b10;
    localparam logic [15:0] LAST_WAIT   = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [15:0] wait_cnt, wait_n;
    logic        cyc_n, stb_n, we_n, rsp_valid_n, err_inc;
    logic [3:0]  sel_n;
    logic [31:0] adr_n, dat_n, rdata_n;
    logic [1:0]  err_n;
    logic [15:0] err_count_n;
    logic        addr_hit;

    assign cmd_ready = (state == IDLE);
    assign addr_hit  = ((cmd_addr & ADDR_MASK) == ADDR_BASE);

    always_comb begin
        state_n     = state;
        wait_n      = wait_cnt;
        cyc_n       = wbs_cyc_o;
        stb_n       = wbs_stb_o;
        we_n        = wbs_we_o;
        sel_n       = wbs_sel_o;
        adr_n       = wbs_adr_o;
        dat_n       = wbs_dat_o;
        rsp_valid_n = rsp_valid;
        rdata_n     = rsp_rdata;
        err_n       = rsp_err;
        err_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    we_n  = cmd_we;
                    adr_n = cmd_addr;
                    dat_n = cmd_wdata;
                    sel_n = cmd_sel;
                    if (addr_hit) begin
                        state_n = BUS;
                        cyc_n   = 1'b1;
                        stb_n   = 1'b1;
                        wait_n  = 16'd0;
                    end else begin
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rdata_n     = 32'd0;
                        err_n       = ERR_DECODE;
                        err_inc     = 1'b1;
                    end
                end
            end
            BUS: begin
                // Ack is tested first so that a last-cycle ack still completes cleanly.
                if (wbs_ack_i) begin
                    state_n     = RESP;
                    cyc_n       = 1'b0;
                    stb_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    rdata_n     = wbs_we_o ? 32'd0 : wbs_dat_i;
                    err_n       = ERR_OK;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_n     = RESP;
                    cyc_n       = 1'b0;
                    stb_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    rdata_n     = 32'd0;
                    err_n       = ERR_TIMEOUT;
                    err_inc     = 1'b1;
                end else begin
                    wait_n = wait_cnt + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        err_count_n = (err_inc && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state     <= IDLE;
            wait_cnt  <= 16'd0;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            wbs_sel_o <= 4'd0;
            wbs_adr_o <= 32'd0;
            wbs_dat_o <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 2'b00;
            busy      <= 1'b0;
            err_count <= 16'd0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            wbs_cyc_o <= cyc_n;
            wbs_stb_o <= stb_n;
            wbs_we_o  <= we_n;
            wbs_sel_o <= sel_n;
            wbs_adr_o <= adr_n;
            wbs_dat_o <= dat_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rdata_n;
            rsp_err   <= err_n;
            busy      <= (state_n != IDLE);
            err_count <= err_count_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_cmd_master
// Brief    : Scoreboard bench for wb_cmd_master with a programmable-wait slave.
// Revision : 1.0
// ============================================================================
module tb_wb_cmd_master;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ack_i;
    logic [3:0]  wbs_sel_o;
    logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
    logic        busy;
    logic [15:0] err_count;

    wb_cmd_master #(
        .TIMEOUT_CYCLES(16),
        .ADDR_BASE     (32'h3000_0000),
        .ADDR_MASK     (32'hF000_0000)
    ) dut (
        .wb_clk   (clk),
        .wb_rst   (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .wbs_cyc_o(wbs_cyc_o),
        .wbs_stb_o(wbs_stb_o),
        .wbs_we_o (wbs_we_o),
        .wbs_sel_o(wbs_sel_o),
        .wbs_adr_o(wbs_adr_o),
        .wbs_dat_o(wbs_dat_o),
        .wbs_ack_i(wbs_ack_i),
        .wbs_dat_i(wbs_dat_i),
        .busy     (busy),
        .err_count(err_count)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          pops     = 0;
    int          slave_wait = 0;
    logic [31:0] slave_rdata = 32'd0;
    int          bcnt   = 0;
    int          cyc_hi = 0;
    logic        last_we  = 1'b0;
    logic [31:0] last_dat = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Slave: acks once the cycle has been held for slave_wait wait states.
    always @(negedge clk) begin
        if (wbs_cyc_o && wbs_stb_o) begin
            cyc_hi++;
            last_we   = wbs_we_o;
            last_dat  = wbs_dat_o;
            wbs_ack_i = (bcnt == slave_wait);
            wbs_dat_i = (bcnt == slave_wait) ? slave_rdata : 32'hBAD0_BAD0;
            bcnt++;
        end else begin
            bcnt      = 0;
            wbs_ack_i = 1'b0;
        end
    end

    // Monitor: one pop per response handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                pops++;
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input logic [31:0] erdata, input logic [1:0] eerr);
        exp_t e;
        logic acc;
        int   g;
        e.rdata = erdata;
        e.err   = eerr;
        exp_q.push_back(e);
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        acc = 1'b0;
        g   = 0;
        while (!acc && g < 200) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            g++;
        end
        cmd_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Returns the latency counted in edges from the start of the accept cycle.
    task automatic wait_rsp(output int lat, output logic ready_low);
        lat       = 0;
        ready_low = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (cmd_ready) ready_low = 1'b0;
        end while (!rsp_valid && lat < 100);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || exp_q.size() != 0) && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic rl;
        logic stable;
        int   pops0;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0; cmd_sel = 4'd0;
        rsp_ready = 1'b1;
        wbs_ack_i = 1'b0; wbs_dat_i = 32'd0;
        #22;
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_cyc", {31'd0, wbs_cyc_o}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_err_count", {16'd0, err_count}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Zero-wait write
        slave_wait = 0; cyc_hi = 0;
        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 32'd0, 2'b00);
        wait_rsp(lat, rl);
        chk("wr_latency", lat, 32'd2);
        wait_idle();
        chk("wr_cyc_cycles", cyc_hi, 32'd1);
        chk("wr_we", {31'd0, last_we}, 32'd1);
        chk("wr_dat", last_dat, 32'hDEAD_BEEF);

        // Read with three wait states
        slave_wait = 3; slave_rdata = 32'h1234_5678; cyc_hi = 0;
        issue(1'b0, 32'h3000_1000, 32'd0, 4'hF, 32'h1234_5678, 2'b00);
        wait_rsp(lat, rl);
        chk("rd_wait_latency", lat, 32'd5);
        chk("rd_wait_ready_low", {31'd0, rl}, 32'd1);
        wait_idle();
        chk("rd_wait_cyc_cycles", cyc_hi, 32'd4);

        // Decode miss
        chk("err_count_before_miss", {16'd0, err_count}, 32'd0);
        cyc_hi = 0;
        issue(1'b0, 32'h2600_0000, 32'd0, 4'hF, 32'd0, 2'b10);
        wait_rsp(lat, rl);
        chk("miss_latency", lat, 32'd1);
        wait_idle();
        chk("miss_cyc_cycles", cyc_hi, 32'd0);
        chk("miss_err_count", {16'd0, err_count}, 32'd1);

        // Timeout: slave never acks
        slave_wait = 1000; cyc_hi = 0;
        issue(1'b0, 32'h3000_0010, 32'd0, 4'hF, 32'd0, 2'b01);
        wait_rsp(lat, rl);
        chk("timeout_latency", lat, 32'd17);
        wait_idle();
        chk("timeout_cyc_cycles", cyc_hi, 32'd16);
        chk("timeout_err_count", {16'd0, err_count}, 32'd2);

        // Ack on the last allowed cycle wins over the timeout
        slave_wait = 15; slave_rdata = 32'hA5A5_5A5A; cyc_hi = 0;
        issue(1'b0, 32'h3000_0014, 32'd0, 4'hF, 32'hA5A5_5A5A, 2'b00);
        wait_rsp(lat, rl);
        chk("lastack_latency", lat, 32'd17);
        wait_idle();
        chk("lastack_cyc_cycles", cyc_hi, 32'd16);
        chk("lastack_err_count", {16'd0, err_count}, 32'd2);

        // Backpressured response with a second command waiting
        slave_wait = 0; slave_rdata = 32'hCAFE_F00D;
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3000_2000, 32'd0, 4'hF, 32'hCAFE_F00D, 2'b00);
        wait_rsp(lat, rl);
        chk("hold_latency", lat, 32'd2);
        cmd_we = 1'b1; cmd_addr = 32'h3000_0008; cmd_wdata = 32'h1122_3344; cmd_sel = 4'h3;
        cmd_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(rsp_valid && rsp_rdata == 32'hCAFE_F00D && rsp_err == 2'b00 && !cmd_ready))
                stable = 1'b0;
        end
        chk("hold_stable", {31'd0, stable}, 32'd1);
        @(posedge clk); #1 rsp_ready = 1'b1;
        pops0 = pops;
        issue(1'b1, 32'h3000_0008, 32'h1122_3344, 4'h3, 32'd0, 2'b00);
        chk("accept_after_rsp", pops, pops0 + 1);
        wait_rsp(lat, rl);
        wait_idle();

        // Asynchronous reset in the second BUS cycle
        slave_wait = 1000;
        issue(1'b0, 32'h3000_3000, 32'd0, 4'hF, 32'd0, 2'b01);
        @(posedge clk); #2;
        chk("pre_reset_cyc", {31'd0, wbs_cyc_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_cyc", {31'd0, wbs_cyc_o}, 32'd0);
        chk("arst_stb", {31'd0, wbs_stb_o}, 32'd0);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_err_count", {16'd0, err_count}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        slave_wait = 0; cyc_hi = 0;
        issue(1'b1, 32'h3000_000C, 32'h55AA_55AA, 4'hF, 32'd0, 2'b00);
        wait_rsp(lat, rl);
        chk("post_reset_latency", lat, 32'd2);
        wait_idle();
        chk("post_reset_cyc_cycles", cyc_hi, 32'd1);
        chk("post_reset_dat", last_dat, 32'h55AA_55AA);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
